// File: rtl/core_data_demux_pkg.sv
// Shared types and address decode for the core data-port demultiplexer.
package core_data_demux_pkg;

  typedef enum logic [1:0] {
    TGT_PERIPH = 2'd0,
    TGT_STACK  = 2'd1,
    TGT_TCDM   = 2'd2
  } target_e;

  localparam int unsigned DEFAULT_ID        = 10;
  localparam int unsigned DEFAULT_HWPE_BIT  = 20;

  // Default-width tag entry; the top re-declares it at its own ID width.
  typedef struct packed {
    target_e                 target;
    logic [DEFAULT_ID-1:0]   tag;
  } fifo_entry_t;

  function automatic target_e decode_target(input logic [31:0] addr,
                                            input int unsigned base_bit = DEFAULT_HWPE_BIT);
    target_e tgt;
    if (addr[base_bit])
      tgt = TGT_PERIPH;
    else if (addr[31:24] == 8'h00)
      tgt = TGT_STACK;
    else
      tgt = TGT_TCDM;
    return tgt;
  endfunction

endpackage

// File: rtl/core_data_demux_fifo.sv
// In-order tag FIFO with a registered head; depth and entry type are parameters.
module core_data_demux_fifo
  import core_data_demux_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = fifo_entry_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= next_ptr(r_wptr);
      end
      if (pop_i) r_rptr <= next_ptr(r_rptr);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_mem[r_rptr];
  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/core_data_demux.sv
// Routes the core data port to PERIPH, STACK or TCDM and steers responses back
// in order using a FIFO of target tags; flags responses that arrive out of turn.
module core_data_demux
  import core_data_demux_pkg::*;
#(
  parameter int unsigned ID                 = 10,
  parameter int unsigned HWPE_ADDR_BASE_BIT = 20,
  parameter int unsigned MAX_OUTSTANDING    = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic          data_err_o,
  output logic [31:0]   data_rdata_o,
  output logic          periph_req_o,
  output logic          periph_wen_o,
  output logic [3:0]    periph_be_o,
  output logic [31:0]   periph_add_o,
  output logic [31:0]   periph_data_o,
  output logic [ID-1:0] periph_id_o,
  input  logic          periph_gnt_i,
  input  logic          periph_r_valid_i,
  input  logic [31:0]   periph_r_data_i,
  input  logic [ID-1:0] periph_r_id_i,
  output logic          stack_req_o,
  output logic          stack_wen_o,
  output logic [3:0]    stack_be_o,
  output logic [31:0]   stack_add_o,
  output logic [31:0]   stack_data_o,
  input  logic          stack_gnt_i,
  input  logic          stack_r_valid_i,
  input  logic [31:0]   stack_r_data_i,
  output logic          tcdm_req_o,
  output logic          tcdm_wen_o,
  output logic [3:0]    tcdm_be_o,
  output logic [31:0]   tcdm_add_o,
  output logic [31:0]   tcdm_data_o,
  input  logic          tcdm_gnt_i,
  input  logic          tcdm_r_valid_i,
  input  logic [31:0]   tcdm_r_data_i,
  output logic          stray_o
);

  typedef struct packed {
    target_e       target;
    logic [ID-1:0] tag;
  } entry_t;

  target_e       w_sel;
  entry_t        w_head;
  entry_t        w_push_entry;
  logic          w_full;
  logic          w_empty;
  logic          w_head_rvalid;
  logic [31:0]   w_head_rdata;
  logic          w_pop;
  logic          w_space;
  logic          w_sel_gnt;
  logic          w_push;
  logic          w_stray_evt;
  logic [ID-1:0] r_tag;
  logic          r_stray;

  assign w_sel = decode_target(data_addr_i, HWPE_ADDR_BASE_BIT);

  always_comb begin
    w_head_rvalid = 1'b0;
    w_head_rdata  = '0;
    case (w_head.target)
      TGT_PERIPH: begin w_head_rvalid = periph_r_valid_i; w_head_rdata = periph_r_data_i; end
      TGT_STACK:  begin w_head_rvalid = stack_r_valid_i;  w_head_rdata = stack_r_data_i;  end
      TGT_TCDM:   begin w_head_rvalid = tcdm_r_valid_i;   w_head_rdata = tcdm_r_data_i;   end
      default:    ;
    endcase
  end

  // A pop in this cycle frees a slot for a same-cycle push even when full.
  assign w_pop   = ~w_empty & w_head_rvalid;
  assign w_space = ~w_full | w_pop;

  always_comb begin
    w_sel_gnt = 1'b0;
    case (w_sel)
      TGT_PERIPH: w_sel_gnt = periph_gnt_i;
      TGT_STACK:  w_sel_gnt = stack_gnt_i;
      TGT_TCDM:   w_sel_gnt = tcdm_gnt_i;
      default:    w_sel_gnt = 1'b0;
    endcase
  end

  assign w_push       = data_req_i & w_sel_gnt & w_space;
  assign w_push_entry = '{target: w_sel, tag: r_tag};

  assign periph_req_o  = data_req_i & (w_sel == TGT_PERIPH) & w_space;
  assign stack_req_o   = data_req_i & (w_sel == TGT_STACK)  & w_space;
  assign tcdm_req_o    = data_req_i & (w_sel == TGT_TCDM)   & w_space;

  assign periph_wen_o  = ~data_we_i;
  assign periph_be_o   = data_be_i;
  assign periph_add_o  = data_addr_i;
  assign periph_data_o = data_wdata_i;
  assign periph_id_o   = r_tag;
  assign stack_wen_o   = ~data_we_i;
  assign stack_be_o    = data_be_i;
  assign stack_add_o   = data_addr_i;
  assign stack_data_o  = data_wdata_i;
  assign tcdm_wen_o    = ~data_we_i;
  assign tcdm_be_o     = data_be_i;
  assign tcdm_add_o    = {8'h00, data_addr_i[23:0]};
  assign tcdm_data_o   = data_wdata_i;

  assign data_gnt_o    = w_push;
  assign data_rvalid_o = w_pop;
  assign data_rdata_o  = w_head_rdata;
  assign data_err_o    = w_pop & (w_head.target == TGT_PERIPH) & (periph_r_id_i != w_head.tag);

  // Any response not coming from the head target is out of turn and dropped.
  assign w_stray_evt = w_empty
    ? (periph_r_valid_i | stack_r_valid_i | tcdm_r_valid_i)
    : ((periph_r_valid_i & (w_head.target != TGT_PERIPH)) |
       (stack_r_valid_i  & (w_head.target != TGT_STACK))  |
       (tcdm_r_valid_i   & (w_head.target != TGT_TCDM)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tag   <= '0;
      r_stray <= 1'b0;
    end else begin
      if (w_push && (w_sel == TGT_PERIPH)) r_tag <= r_tag + 1'b1;
      if (w_stray_evt) r_stray <= 1'b1;
    end
  end

  assign stray_o = r_stray;

  core_data_demux_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule

// File: tb/tb_core_data_demux.sv
// Self-checking bench for core_data_demux: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_core_data_demux;

  localparam int ID   = 10;
  localparam int BASE = 20;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          dataReq, dataWe, dataGnt, dataRvalid, dataErr;
  logic [3:0]    dataBe;
  logic [31:0]   dataAddr, dataWdata, dataRdata;
  logic          periphReq, periphWen, periphGnt, periphRv;
  logic [3:0]    periphBe;
  logic [31:0]   periphAdd, periphData, periphRd;
  logic [ID-1:0] periphId, periphRid;
  logic          stackReq, stackWen, stackGnt, stackRv;
  logic [3:0]    stackBe;
  logic [31:0]   stackAdd, stackData, stackRd;
  logic          tcdmReq, tcdmWen, tcdmGnt, tcdmRv;
  logic [3:0]    tcdmBe;
  logic [31:0]   tcdmAdd, tcdmData, tcdmRd;
  logic          strayO;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: outstanding transactions in issue order, next tag, stray flag.
  typedef struct { int tgt; int tag; } ent_t;
  ent_t q[$];
  int   mTag   = 0;
  bit   mStray = 1'b0;

  always #5 clk = ~clk;

  core_data_demux #(.ID(ID), .HWPE_ADDR_BASE_BIT(BASE), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .data_req_i(dataReq), .data_we_i(dataWe), .data_be_i(dataBe),
    .data_addr_i(dataAddr), .data_wdata_i(dataWdata),
    .data_gnt_o(dataGnt), .data_rvalid_o(dataRvalid), .data_err_o(dataErr),
    .data_rdata_o(dataRdata),
    .periph_req_o(periphReq), .periph_wen_o(periphWen), .periph_be_o(periphBe),
    .periph_add_o(periphAdd), .periph_data_o(periphData), .periph_id_o(periphId),
    .periph_gnt_i(periphGnt), .periph_r_valid_i(periphRv), .periph_r_data_i(periphRd),
    .periph_r_id_i(periphRid),
    .stack_req_o(stackReq), .stack_wen_o(stackWen), .stack_be_o(stackBe),
    .stack_add_o(stackAdd), .stack_data_o(stackData),
    .stack_gnt_i(stackGnt), .stack_r_valid_i(stackRv), .stack_r_data_i(stackRd),
    .tcdm_req_o(tcdmReq), .tcdm_wen_o(tcdmWen), .tcdm_be_o(tcdmBe),
    .tcdm_add_o(tcdmAdd), .tcdm_data_o(tcdmData),
    .tcdm_gnt_i(tcdmGnt), .tcdm_r_valid_i(tcdmRv), .tcdm_r_data_i(tcdmRd),
    .stray_o(strayO)
  );

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expVal);
    nCompared++;
    if (obs !== expVal) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expVal);
    end
  endtask

  // gnt/rv bit 0 = PERIPH, 1 = STACK, 2 = TCDM; each target returns distinct data.
  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [2:0] gnt, input logic [2:0] rv,
                               input logic [31:0] rd, input logic [ID-1:0] rid);
    dataReq = req;  dataWe = we;  dataAddr = addr;  dataWdata = wdata;  dataBe = be;
    periphGnt = gnt[0];  stackGnt = gnt[1];  tcdmGnt = gnt[2];
    periphRv  = rv[0];   stackRv  = rv[1];   tcdmRv  = rv[2];
    stackRd   = rd;
    periphRd  = rd ^ 32'h1111_1111;
    tcdmRd    = rd ^ 32'h2222_2222;
    periphRid = rid;
  endtask

  function automatic int decodeTgt(input logic [31:0] a);
    if (a[BASE]) return 0;
    if (a[31:24] == 8'h00) return 1;
    return 2;
  endfunction

  // Compare all outputs against the model mid-cycle, then advance the model at the edge.
  task automatic stepCycle();
    int          tgt;
    bit          pop, space, gntExp, strayEvt, errExp;
    logic [2:0]  rvv, gv, reqExp, reqObs;
    logic [31:0] rdExp, addExp;
    logic [68:0] fExp, fObs;
    @(negedge clk);
    tgt    = decodeTgt(dataAddr);
    rvv    = {tcdmRv, stackRv, periphRv};
    gv     = {tcdmGnt, stackGnt, periphGnt};
    pop    = (q.size() > 0) && rvv[q[0].tgt];
    space  = (q.size() < MAXO) || pop;
    gntExp = dataReq && gv[tgt] && space;
    reqExp = (dataReq && space) ? 3'(1 << tgt) : 3'b000;
    reqObs = {tcdmReq, stackReq, periphReq};
    checkOutput("req", reqObs, reqExp);
    checkOutput("gnt", dataGnt, gntExp);
    checkOutput("rvalid", dataRvalid, pop);
    checkOutput("stray", strayO, mStray);
    checkOutput("periph_id", periphId, mTag);
    errExp = 1'b0;
    if (pop) begin
      rdExp = (q[0].tgt == 0) ? periphRd : (q[0].tgt == 1) ? stackRd : tcdmRd;
      checkOutput("rdata", dataRdata, rdExp);
      errExp = (q[0].tgt == 0) && (int'(periphRid) != q[0].tag);
    end
    checkOutput("err", dataErr, errExp);
    addExp = (tgt == 2) ? {8'h00, dataAddr[23:0]} : dataAddr;
    fExp   = {~dataWe, dataBe, addExp, dataWdata};
    case (tgt)
      0:       fObs = {periphWen, periphBe, periphAdd, periphData};
      1:       fObs = {stackWen, stackBe, stackAdd, stackData};
      default: fObs = {tcdmWen, tcdmBe, tcdmAdd, tcdmData};
    endcase
    checkOutput("fields", fObs, fExp);
    strayEvt = 1'b0;
    for (int t = 0; t < 3; t++)
      if (rvv[t] && (q.size() == 0 || t != q[0].tgt)) strayEvt = 1'b1;
    @(posedge clk);
    if (pop) q.delete(0);
    if (gntExp) begin
      q.push_back('{tgt, mTag});
      if (tgt == 0) mTag = (mTag + 1) % (1 << ID);
    end
    if (strayEvt) mStray = 1'b1;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
    rstN = 1'b0;
    #2;
    q.delete();
    mTag   = 0;
    mStray = 1'b0;
    checkOutput("rst_stray", strayO, 0);
    checkOutput("rst_gnt", dataGnt, 0);
    checkOutput("rst_id", periphId, 0);
    checkOutput("rst_req", {tcdmReq, stackReq, periphReq}, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic randomPhase(input int cycles, input bit allowStray);
    logic [31:0] addr;
    logic [2:0]  rv;
    logic [ID-1:0] rid;
    int mode;
    for (int c = 0; c < cycles; c++) begin
      mode = $urandom_range(0, 2);
      addr = $urandom;
      if (mode == 0) addr[BASE] = 1'b1;
      else begin
        addr[BASE] = 1'b0;
        if (mode == 1) addr[31:24] = 8'h00;
        else if (addr[31:24] == 8'h00) addr[31:24] = 8'h1A;
      end
      rv  = 3'b000;
      rid = ID'($urandom);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rv[q[0].tgt] = 1'b1;
        if (q[0].tgt == 0 && $urandom_range(0, 3) != 0) rid = ID'(q[0].tag);
      end
      if (allowStray && $urandom_range(0, 49) == 0) rv[$urandom_range(0, 2)] = 1'b1;
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), addr, $urandom,
                    4'($urandom), 3'($urandom), rv, $urandom, rid);
      stepCycle();
    end
  endtask

  initial begin
    doReset();

    // Stack read answered the following cycle.
    applyStimulus(1, 0, 32'h0000_1000, 0, 4'hF, 3'b010, 3'b000, 0, 0);
    #1;
    checkOutput("t1_stack_req", stackReq, 1);
    checkOutput("t1_stack_wen", stackWen, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b010, 32'hDEAD_BEEF, 0);
    #1;
    checkOutput("t1_rvalid", dataRvalid, 1);
    checkOutput("t1_rdata", dataRdata, 32'hDEAD_BEEF);
    stepCycle();

    // TCDM write address remap, then PERIPH tag sequencing.
    applyStimulus(1, 1, 32'h1A00_0010, 32'h1234_5678, 4'h3, 3'b100, 3'b000, 0, 0);
    #1;
    checkOutput("t2_tcdm_add", tcdmAdd, 32'h0000_0010);
    checkOutput("t2_tcdm_wen", tcdmWen, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b100, 32'h55, 0);
    stepCycle();
    applyStimulus(1, 1, 32'h0010_0004, 32'hAB, 4'hF, 3'b001, 3'b000, 0, 0);
    #1;
    checkOutput("t2_periph_req", periphReq, 1);
    checkOutput("t2_periph_id0", periphId, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b001, 32'h77, 0);
    stepCycle();
    applyStimulus(1, 0, 32'h0010_0008, 0, 4'hF, 3'b001, 3'b000, 0, 0);
    #1;
    checkOutput("t2_periph_id1", periphId, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b001, 32'h78, 1);
    #1;
    checkOutput("t2_err_ok", dataErr, 0);
    stepCycle();

    // Full FIFO: third request held off until a response frees a slot.
    applyStimulus(1, 0, 32'h0000_0100, 0, 4'hF, 3'b010, 3'b000, 0, 0);
    stepCycle();
    applyStimulus(1, 0, 32'h2000_0000, 0, 4'hF, 3'b100, 3'b000, 0, 0);
    stepCycle();
    applyStimulus(1, 0, 32'h0000_0104, 0, 4'hF, 3'b010, 3'b000, 0, 0);
    #1;
    checkOutput("t4_full_gnt", dataGnt, 0);
    checkOutput("t4_full_req", {tcdmReq, stackReq, periphReq}, 0);
    stepCycle();
    applyStimulus(1, 0, 32'h0000_0104, 0, 4'hF, 3'b010, 3'b010, 32'hA5A5, 0);
    #1;
    checkOutput("t4_pushpop_gnt", dataGnt, 1);
    stepCycle();
    applyStimulus(1, 0, 32'h0000_0108, 0, 4'hF, 3'b010, 3'b000, 0, 0);
    #1;
    checkOutput("t4_still_full", dataGnt, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b100, 32'h1, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b010, 32'h2, 0);
    stepCycle();

    // Advance the tag to 4, then answer with the wrong ID.
    for (int t = 2; t < 4; t++) begin
      applyStimulus(1, 0, 32'h0010_0000, 0, 4'hF, 3'b001, 3'b000, 0, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b001, 32'h9, ID'(t));
      stepCycle();
    end
    applyStimulus(1, 0, 32'h0010_0000, 0, 4'hF, 3'b001, 3'b000, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b001, 32'h9, 10'd5);
    #1;
    checkOutput("t5_rvalid", dataRvalid, 1);
    checkOutput("t5_err", dataErr, 1);
    stepCycle();

    // Out-of-order STACK response is dropped; PERIPH response still delivered.
    applyStimulus(1, 0, 32'h0010_0000, 0, 4'hF, 3'b001, 3'b000, 0, 0);
    stepCycle();
    applyStimulus(1, 0, 32'h0000_0200, 0, 4'hF, 3'b010, 3'b000, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b010, 32'hBAD0, 0);
    #1;
    checkOutput("t3_drop", dataRvalid, 0);
    stepCycle();
    checkOutput("t3_stray", strayO, 1);
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b001, 32'hCAFE_0000, 10'd5);
    #1;
    checkOutput("t3_periph_rvalid", dataRvalid, 1);
    checkOutput("t3_periph_rdata", dataRdata, 32'hDBEF_1111);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b010, 32'h3, 0);
    stepCycle();

    // Reset with one request outstanding; its late response becomes stray.
    doReset();
    applyStimulus(1, 0, 32'h0010_0000, 0, 4'hF, 3'b001, 3'b000, 0, 0);
    stepCycle();
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b001, 32'h44, 0);
    #1;
    checkOutput("t6_no_rvalid", dataRvalid, 0);
    stepCycle();
    checkOutput("t6_stray", strayO, 1);
    checkOutput("t6_tag", periphId, 0);

    doReset();
    randomPhase(500, 1'b0);
    doReset();
    randomPhase(600, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/core_data_demux.md
# core_data_demux

Routes the zeroriscy core data port of the FIR HWPE system to three targets: the HWPE peripheral (control) port, the stack memory and the shared TCDM port. It sits directly upstream of `fir_top_wrap`'s periph port. It replaces ad-hoc combinational steering with tracked routing: an in-order FIFO of target tags steers each response to the core, checks peripheral response IDs and flags stray responses.

## Interface
- `ID`, 10: peripheral transaction ID width.
- `HWPE_ADDR_BASE_BIT`, 20: address bit selecting the HWPE peripheral.
- `MAX_OUTSTANDING`, 2: tag FIFO depth (≥1).
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `data_req_i`, `data_we_i` in 1; `data_be_i` in 4; `data_addr_i`, `data_wdata_i` in 32: core request.
- `data_gnt_o`, `data_rvalid_o`, `data_err_o` out 1; `data_rdata_o` out 32: core grant and response.
- `periph_req_o`, `periph_wen_o` out 1; `periph_be_o` out 4; `periph_add_o`, `periph_data_o` out 32; `periph_id_o` out ID: peripheral request. `wen` = 1 means read.
- `periph_gnt_i`, `periph_r_valid_i` in 1; `periph_r_data_i` in 32; `periph_r_id_i` in ID: peripheral grant and response.
- `stack_*` and `tcdm_*`: `req_o`, `wen_o`, `be_o`[4], `add_o`[32], `data_o`[32] out; `gnt_i`, `r_valid_i`, `r_data_i`[32] in.
- `stray_o` out 1: sticky flag, set when a response arrives that does not match the FIFO head.

## Operation
- Decode, evaluated in priority order:
  - `addr[HWPE_ADDR_BASE_BIT]` = 1 → PERIPH.
  - else `addr[31:24]` = 0 → STACK.
  - else → TCDM.
- Address mapping:
  - TCDM: `add_o` = {8'h0, addr[23:0]}.
  - STACK and PERIPH: full address.
- Request fields: `wen_o` = ~`data_we_i`; `be` and `data` pass through unchanged.
- `space` = FIFO not full, or a pop occurs in the same cycle.
- `<tgt>_req_o` = `data_req_i` & sel & `space`. Non-selected targets have req = 0.
- `data_gnt_o` = selected `gnt_i` & `space`.
- On grant:
  - Push {target, tag} into the FIFO.
  - `periph_id_o` carries `tag_q`.
  - `tag_q` increments modulo 2^ID on every PERIPH grant only.
- Response path (FIFO non-empty):
  - Only the head target's `r_valid` is forwarded: `data_rvalid_o` = head `r_valid`, `data_rdata_o` = head `r_data`.
  - A forwarded response pops the FIFO.
- `data_err_o` = `data_rvalid_o` & head is PERIPH & `periph_r_id_i` ≠ head tag.
- Stray detection: `stray_o` sets on any `r_valid` from a non-head target, or on any `r_valid` while the FIFO is empty. Stray responses are dropped. `stray_o` clears only on reset.
- Reset mid-operation clears the FIFO. Responses arriving afterwards are stray.

## Timing
- Request path is zero latency: core request to target request, and target grant to core grant, are combinational.
- Response path is zero latency: target response to core response is combinational. The FIFO head is registered.
- The push-and-pop-in-same-cycle path (`r_valid` → `space` → `gnt`) is intentional. Synthesis constrains it as a single-cycle path.
- Reset values:
  - FIFO empty, `tag_q` = 0, `stray_o` = 0.
  - All `req_o`, `data_gnt_o`, `data_rvalid_o`, `data_err_o` = 0.
- Full FIFO with no pop: `data_gnt_o` = 0 and all target `req_o` = 0. The core request must stay stable until granted; this is the core's obligation.
- A push and pop in the same cycle when full leaves the count unchanged. Pointers wrap modulo `MAX_OUTSTANDING`.

## Structure
- Package `core_data_demux_pkg` holds:
  - `target_e` (2-bit: `TGT_PERIPH`=0, `TGT_STACK`=1, `TGT_TCDM`=2).
  - `fifo_entry_t` {target_e target; logic [ID-1:0] tag}.
  - Function `decode_target(addr)`.
- Sub-module `core_data_demux_fifo`:
  - Parametrised depth and type.
  - Ports: push, pop, head, full, empty.
  - Same clock and asynchronous active-low reset.

## Test plan
- Read 0x0000_1000, STACK grants and responds in 1 cycle with 0xDEAD_BEEF → `stack_req_o` = 1, `stack_wen_o` = 1; next cycle `data_rvalid_o` = 1, `data_rdata_o` = 0xDEAD_BEEF.
- Write 0x1A00_0010 (bit 20 = 0, TCDM) → `tcdm_add_o` = 0x0000_0010, `tcdm_wen_o` = 0. Write 0x0010_0004 → routed to PERIPH with `periph_id_o` = 0; the next PERIPH access gets id 1.
- Two back-to-back grants (PERIPH then STACK), with STACK responding before PERIPH → STACK response dropped, `stray_o` = 1; the PERIPH response is still delivered.
- Two outstanding requests with no responses → the third request sees `data_gnt_o` = 0 and all `req_o` = 0. A response plus the third request in the same cycle → granted, count stays 2.
- PERIPH response with `r_id` = 5 while head tag = 4 → `data_rvalid_o` = 1 with `data_err_o` = 1.
- Assert `rst_ni` with 1 outstanding request, then the target responds → no `data_rvalid_o`, `stray_o` = 1, `tag_q` = 0.
